rob_multi_issue: RTL and testbench

//  Parametrised reorder buffer; successor to the single-issue ROB. Per cycle it accepts up to DISP_W

---
 rtl/rob_pkg.sv | 31 +++
 rtl/rob_ptr_ctrl.sv | 67 ++++++
 rtl/rob_multi_issue.sv | 165 ++++++++++++++++
 tb/tb_rob_multi_issue.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// Shared types and tag helpers for the multi-issue reorder buffer.
package rob_pkg;

  localparam int unsigned ROB_DEC_W = 9;
  localparam int unsigned ROB_CPL_W = 70;

  typedef struct packed {
    logic [ROB_DEC_W-1:0] bits;
  } rob_dec_t;

  typedef struct packed {
    logic [ROB_CPL_W-1:0] bits;
  } rob_cpl_t;

  typedef struct packed {
    logic     valid;
    logic     done;
    rob_dec_t dec;
    rob_cpl_t cpl;
  } rob_entry_t;

  // Tags are 1-based so that tag 0 can mean "no entry".
  function automatic logic [31:0] idx2tag(input logic [31:0] idx);
    return idx + 32'd1;
  endfunction

  function automatic logic [31:0] tag2idx(input logic [31:0] tag);
    return tag - 32'd1;
  endfunction

endpackage

// File: rtl/rob_ptr_ctrl.sv
// Head/tail/count bookkeeping for the ROB: dispatch acceptance, commit clamp and flush.
module rob_ptr_ctrl #(
  parameter int unsigned ROBSIZE  = 32,
  parameter int unsigned DISP_W   = 2,
  parameter int unsigned COMMIT_W = 2,
  localparam int unsigned AW  = $clog2(ROBSIZE),
  localparam int unsigned CW  = $clog2(ROBSIZE + 1),
  localparam int unsigned CCW = $clog2(COMMIT_W + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic [DISP_W-1:0]   disp_valid,
  input  logic [COMMIT_W-1:0] commit_ready,
  input  logic [CCW-1:0]      commit_cnt,
  output logic [AW-1:0]       head,
  output logic [AW-1:0]       tail,
  output logic [CW-1:0]       count,
  output logic                stall,
  output logic                empty,
  output logic                disp_fire_c,
  output logic [CCW-1:0]      retire_cnt_c
);

  logic [CW-1:0]  disp_n;
  logic [CW-1:0]  acc_n;
  logic [CW-1:0]  count_next;
  logic [CCW-1:0] ready_n;
  logic [AW-1:0]  head_next;
  logic [AW-1:0]  tail_next;

  // Ready lanes are a prefix, so their popcount is the leading-ready count.
  always_comb begin
    disp_n  = '0;
    ready_n = '0;
    for (int l = 0; l < DISP_W; l++) disp_n = disp_n + CW'(disp_valid[l]);
    for (int k = 0; k < COMMIT_W; k++) ready_n = ready_n + CCW'(commit_ready[k]);
    retire_cnt_c = (commit_cnt < ready_n) ? commit_cnt : ready_n;
    disp_fire_c  = !stall && (disp_valid != '0);
    acc_n        = disp_fire_c ? disp_n : '0;
    count_next   = count + acc_n - CW'(retire_cnt_c);
    head_next    = head + AW'(retire_cnt_c);
    tail_next    = tail + AW'(acc_n);
    if (flush) begin
      count_next = '0;
      head_next  = '0;
      tail_next  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      stall <= 1'b0;
      empty <= 1'b1;
    end else begin
      head  <= head_next;
      tail  <= tail_next;
      count <= count_next;
      stall <= count_next > CW'(ROBSIZE - DISP_W);
      empty <= count_next == '0;
    end
  end

endmodule

// File: rtl/rob_multi_issue.sv
// Multi-issue reorder buffer: entry array with dispatch, completion, operand read and in-order commit.
module rob_multi_issue
  import rob_pkg::*;
#(
  parameter int unsigned ROBSIZE  = 32,
  parameter int unsigned DISP_W   = 2,
  parameter int unsigned COMMIT_W = 2,
  parameter int unsigned CPL_P    = 2,
  parameter int unsigned RD_P     = 2,
  parameter int unsigned DEC_W    = ROB_DEC_W,
  parameter int unsigned CPL_W    = ROB_CPL_W,
  localparam int unsigned AW  = $clog2(ROBSIZE),
  localparam int unsigned TW  = AW + 1,
  localparam int unsigned CW  = $clog2(ROBSIZE + 1),
  localparam int unsigned CCW = $clog2(COMMIT_W + 1)
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic                              flush_i,
  input  logic [DISP_W-1:0]                 disp_valid_i,
  input  logic [DISP_W*DEC_W-1:0]           disp_data_i,
  output logic [DISP_W*TW-1:0]              disp_tag_o,
  output logic                              stall_o,
  input  logic [CPL_P-1:0]                  cpl_valid_i,
  input  logic [CPL_P*TW-1:0]               cpl_tag_i,
  input  logic [CPL_P*CPL_W-1:0]            cpl_data_i,
  input  logic [RD_P*TW-1:0]                rd_tag_i,
  output logic [RD_P-1:0]                   rd_done_o,
  output logic [RD_P*CPL_W-1:0]             rd_data_o,
  output logic [COMMIT_W-1:0]               commit_valid_o,
  output logic [COMMIT_W*TW-1:0]            commit_tag_o,
  output logic [COMMIT_W*(DEC_W+CPL_W)-1:0] commit_data_o,
  input  logic [CCW-1:0]                    commit_cnt_i,
  output logic [CW-1:0]                     count_o,
  output logic                              empty_o
);

  localparam int unsigned CDW = DEC_W + CPL_W;

  rob_entry_t     rob_q [ROBSIZE];
  logic [AW-1:0]  head;
  logic [AW-1:0]  tail;
  logic           disp_fire_c;
  logic [CCW-1:0] retire_cnt_c;
  logic [AW-1:0]  disp_idx [DISP_W];
  logic [AW-1:0]  cmt_idx  [COMMIT_W];
  logic [AW-1:0]  cpl_idx  [CPL_P];
  logic [AW-1:0]  rd_idx   [RD_P];
  logic [TW-1:0]  cpl_tag  [CPL_P];
  logic [TW-1:0]  rd_tag   [RD_P];
  logic [CPL_P-1:0] cpl_hit;
  logic           cmt_chain;

  // Tag 0 and tags beyond ROBSIZE name no entry.
  function automatic logic tag_ok(input logic [TW-1:0] t);
    return (t != '0) && (32'(t) <= ROBSIZE);
  endfunction

  function automatic logic [AW-1:0] t2i(input logic [TW-1:0] t);
    return AW'(tag2idx(32'(t)));
  endfunction

  rob_ptr_ctrl #(
    .ROBSIZE  (ROBSIZE),
    .DISP_W   (DISP_W),
    .COMMIT_W (COMMIT_W)
  ) u_ptr (
    .clk          (clk_i),
    .rst          (reset_i),
    .flush        (flush_i),
    .disp_valid   (disp_valid_i),
    .commit_ready (commit_valid_o),
    .commit_cnt   (commit_cnt_i),
    .head         (head),
    .tail         (tail),
    .count        (count_o),
    .stall        (stall_o),
    .empty        (empty_o),
    .disp_fire_c  (disp_fire_c),
    .retire_cnt_c (retire_cnt_c)
  );

  always_comb begin
    for (int l = 0; l < DISP_W; l++) begin
      disp_idx[l] = tail + AW'(l);
      disp_tag_o[l*TW +: TW] = TW'(idx2tag(32'(disp_idx[l])));
    end
  end

  // A completion only lands on an entry that is currently valid.
  always_comb begin
    for (int p = 0; p < CPL_P; p++) begin
      cpl_tag[p] = cpl_tag_i[p*TW +: TW];
      cpl_idx[p] = t2i(cpl_tag[p]);
      cpl_hit[p] = cpl_valid_i[p] && tag_ok(cpl_tag[p]) && rob_q[cpl_idx[p]].valid;
    end
  end

  // Operand read with same-cycle completion forwarding; highest port wins.
  always_comb begin
    rd_done_o = '0;
    rd_data_o = '0;
    for (int r = 0; r < RD_P; r++) begin
      rd_tag[r] = rd_tag_i[r*TW +: TW];
      rd_idx[r] = t2i(rd_tag[r]);
      if (tag_ok(rd_tag[r]) && rob_q[rd_idx[r]].valid) begin
        rd_done_o[r]             = rob_q[rd_idx[r]].done;
        rd_data_o[r*CPL_W +: CPL_W] = rob_q[rd_idx[r]].cpl;
        for (int p = 0; p < CPL_P; p++) begin
          if (cpl_hit[p] && (cpl_tag[p] == rd_tag[r])) begin
            rd_done_o[r]             = 1'b1;
            rd_data_o[r*CPL_W +: CPL_W] = cpl_data_i[p*CPL_W +: CPL_W];
          end
        end
      end
    end
  end

  always_comb begin
    cmt_chain = 1'b1;
    for (int k = 0; k < COMMIT_W; k++) begin
      cmt_idx[k] = head + AW'(k);
      cmt_chain  = cmt_chain && rob_q[cmt_idx[k]].valid && rob_q[cmt_idx[k]].done
                   && (CW'(k) < count_o);
      commit_valid_o[k]          = cmt_chain;
      commit_tag_o[k*TW +: TW]   = TW'(idx2tag(32'(cmt_idx[k])));
      commit_data_o[k*CDW +: CDW] = {rob_q[cmt_idx[k]].dec, rob_q[cmt_idx[k]].cpl};
    end
  end

  // Later assignments win: dispatch over retire over completion.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < ROBSIZE; i++) rob_q[i] <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < ROBSIZE; i++) begin
        rob_q[i].valid <= 1'b0;
        rob_q[i].done  <= 1'b0;
      end
    end else begin
      for (int p = 0; p < CPL_P; p++) begin
        if (cpl_hit[p]) begin
          rob_q[cpl_idx[p]].done <= 1'b1;
          rob_q[cpl_idx[p]].cpl  <= cpl_data_i[p*CPL_W +: CPL_W];
        end
      end
      for (int k = 0; k < COMMIT_W; k++) begin
        if (CCW'(k) < retire_cnt_c) begin
          rob_q[cmt_idx[k]].valid <= 1'b0;
          rob_q[cmt_idx[k]].done  <= 1'b0;
        end
      end
      if (disp_fire_c) begin
        for (int l = 0; l < DISP_W; l++) begin
          if (disp_valid_i[l]) begin
            rob_q[disp_idx[l]].valid <= 1'b1;
            rob_q[disp_idx[l]].done  <= 1'b0;
            rob_q[disp_idx[l]].dec   <= disp_data_i[l*DEC_W +: DEC_W];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rob_multi_issue.sv
// Directed plus randomized bench for rob_multi_issue against an in-order queue model.
module tb_rob_multi_issue;

  localparam int unsigned ROBSIZE  = 8;
  localparam int unsigned DISP_W   = 2;
  localparam int unsigned COMMIT_W = 2;
  localparam int unsigned CPL_P    = 2;
  localparam int unsigned RD_P     = 2;
  localparam int unsigned DEC_W    = 9;
  localparam int unsigned CPL_W    = 70;
  localparam int unsigned TW       = 4;
  localparam int unsigned CW       = 4;
  localparam int unsigned CCW      = 2;
  localparam int unsigned CDW      = DEC_W + CPL_W;

  logic                       clk = 1'b0;
  logic                       reset_i;
  logic                       flush_i;
  logic [DISP_W-1:0]          disp_valid_i;
  logic [DISP_W*DEC_W-1:0]    disp_data_i;
  logic [DISP_W*TW-1:0]       disp_tag_o;
  logic                       stall_o;
  logic [CPL_P-1:0]           cpl_valid_i;
  logic [CPL_P*TW-1:0]        cpl_tag_i;
  logic [CPL_P*CPL_W-1:0]     cpl_data_i;
  logic [RD_P*TW-1:0]         rd_tag_i;
  logic [RD_P-1:0]            rd_done_o;
  logic [RD_P*CPL_W-1:0]      rd_data_o;
  logic [COMMIT_W-1:0]        commit_valid_o;
  logic [COMMIT_W*TW-1:0]     commit_tag_o;
  logic [COMMIT_W*CDW-1:0]    commit_data_o;
  logic [CCW-1:0]             commit_cnt_i;
  logic [CW-1:0]              count_o;
  logic                       empty_o;

  always #5 clk = ~clk;

  rob_multi_issue #(
    .ROBSIZE(ROBSIZE), .DISP_W(DISP_W), .COMMIT_W(COMMIT_W), .CPL_P(CPL_P),
    .RD_P(RD_P), .DEC_W(DEC_W), .CPL_W(CPL_W)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .flush_i(flush_i),
    .disp_valid_i(disp_valid_i), .disp_data_i(disp_data_i), .disp_tag_o(disp_tag_o),
    .stall_o(stall_o), .cpl_valid_i(cpl_valid_i), .cpl_tag_i(cpl_tag_i),
    .cpl_data_i(cpl_data_i), .rd_tag_i(rd_tag_i), .rd_done_o(rd_done_o),
    .rd_data_o(rd_data_o), .commit_valid_o(commit_valid_o), .commit_tag_o(commit_tag_o),
    .commit_data_o(commit_data_o), .commit_cnt_i(commit_cnt_i), .count_o(count_o),
    .empty_o(empty_o)
  );

  // Model: occupied entries in program order, oldest first.
  typedef struct {
    logic [TW-1:0]    tag;
    logic [DEC_W-1:0] dec;
    logic [CPL_W-1:0] cpl;
    bit               done;
  } ment_t;

  ment_t mq[$];
  int    m_tail;
  int    checks;
  int    fails;

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic int find_tag(input logic [TW-1:0] t);
    foreach (mq[i]) if (mq[i].tag == t) return i;
    return -1;
  endfunction

  task automatic idle();
    flush_i      = 1'b0;
    disp_valid_i = '0;
    disp_data_i  = '0;
    cpl_valid_i  = '0;
    cpl_tag_i    = '0;
    cpl_data_i   = '0;
    rd_tag_i     = '0;
    commit_cnt_i = '0;
  endtask

  task automatic check_outputs();
    int               n;
    bit               chain;
    int               idx;
    bit               ed;
    logic [CPL_W-1:0] edata;
    logic [TW-1:0]    t;
    n     = mq.size();
    chain = 1'b1;
    chk("count", 128'(count_o), 128'(n));
    chk("empty", 128'(empty_o), 128'(n == 0));
    chk("stall", 128'(stall_o), 128'(n > int'(ROBSIZE - DISP_W)));
    for (int l = 0; l < DISP_W; l++)
      chk($sformatf("disp_tag%0d", l), 128'(disp_tag_o[l*TW +: TW]),
          128'((m_tail + l) % ROBSIZE + 1));
    for (int k = 0; k < COMMIT_W; k++) begin
      chain = chain && (k < n) && mq[k].done;
      chk($sformatf("commit_valid%0d", k), 128'(commit_valid_o[k]), 128'(chain));
      if (chain) begin
        chk($sformatf("commit_tag%0d", k), 128'(commit_tag_o[k*TW +: TW]), 128'(mq[k].tag));
        chk($sformatf("commit_data%0d", k), 128'(commit_data_o[k*CDW +: CDW]),
            128'({mq[k].dec, mq[k].cpl}));
      end
    end
    for (int r = 0; r < RD_P; r++) begin
      t     = rd_tag_i[r*TW +: TW];
      idx   = find_tag(t);
      ed    = 1'b0;
      edata = '0;
      if (idx >= 0) begin
        ed    = mq[idx].done;
        edata = mq[idx].cpl;
        for (int p = 0; p < CPL_P; p++)
          if (cpl_valid_i[p] && cpl_tag_i[p*TW +: TW] == t) begin
            ed    = 1'b1;
            edata = cpl_data_i[p*CPL_W +: CPL_W];
          end
      end
      chk($sformatf("rd_done%0d", r), 128'(rd_done_o[r]), 128'(ed));
      if (ed) chk($sformatf("rd_data%0d", r), 128'(rd_data_o[r*CPL_W +: CPL_W]), 128'(edata));
    end
  endtask

  // Applies one clock edge of the rules to the model, using the inputs held across that edge.
  task automatic model_edge();
    int    ready;
    int    retire;
    int    idx;
    bit    stalled;
    ment_t e;
    if (flush_i) begin
      mq.delete();
      m_tail = 0;
      return;
    end
    ready = 0;
    for (int k = 0; k < COMMIT_W; k++) begin
      if (k < mq.size() && mq[k].done) ready++;
      else break;
    end
    stalled = mq.size() > int'(ROBSIZE - DISP_W);
    for (int p = 0; p < CPL_P; p++) begin
      if (cpl_valid_i[p]) begin
        idx = find_tag(cpl_tag_i[p*TW +: TW]);
        if (idx >= 0) begin
          mq[idx].done = 1'b1;
          mq[idx].cpl  = cpl_data_i[p*CPL_W +: CPL_W];
        end
      end
    end
    retire = (int'(commit_cnt_i) < ready) ? int'(commit_cnt_i) : ready;
    repeat (retire) void'(mq.pop_front());
    if (!stalled) begin
      for (int l = 0; l < DISP_W; l++) begin
        if (disp_valid_i[l]) begin
          e.tag  = TW'(m_tail + 1);
          e.dec  = disp_data_i[l*DEC_W +: DEC_W];
          e.cpl  = '0;
          e.done = 1'b0;
          mq.push_back(e);
          m_tail = (m_tail + 1) % ROBSIZE;
        end
      end
    end
  endtask

  // Called at a negedge with inputs set; returns at the next negedge.
  task automatic cycle();
    #1;
    check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic disp2();
    idle();
    disp_valid_i = 2'b11;
    disp_data_i  = 18'($urandom);
    cycle();
  endtask

  task automatic cpl1(input logic [TW-1:0] t, input logic [CPL_W-1:0] d);
    idle();
    cpl_valid_i      = 2'b01;
    cpl_tag_i[TW-1:0] = t;
    cpl_data_i[CPL_W-1:0] = d;
    cycle();
  endtask

  task automatic pick_tag(output logic [TW-1:0] t);
    if (mq.size() > 0 && $urandom_range(0, 3) != 0) t = mq[$urandom_range(0, mq.size() - 1)].tag;
    else t = TW'($urandom);
  endtask

  task automatic random_cycle();
    logic [TW-1:0] t;
    idle();
    case ($urandom_range(0, 2))
      0: disp_valid_i = 2'b00;
      1: disp_valid_i = 2'b01;
      default: disp_valid_i = 2'b11;
    endcase
    disp_data_i = 18'($urandom);
    for (int p = 0; p < CPL_P; p++) begin
      cpl_valid_i[p] = 1'($urandom_range(0, 1));
      pick_tag(t);
      cpl_tag_i[p*TW +: TW]     = t;
      cpl_data_i[p*CPL_W +: CPL_W] = CPL_W'({$urandom, $urandom, $urandom});
    end
    for (int r = 0; r < RD_P; r++) begin
      pick_tag(t);
      rd_tag_i[r*TW +: TW] = t;
    end
    commit_cnt_i = 2'($urandom_range(0, 3));
    flush_i      = ($urandom_range(0, 29) == 0);
    cycle();
  endtask

  initial begin
    checks  = 0;
    fails   = 0;
    m_tail  = 0;
    reset_i = 1'b1;
    idle();
    rd_tag_i = {4'd2, 4'd1};
    #12;
    check_outputs();
    chk("rst_disp_tag", 128'(disp_tag_o), 128'(8'h21));
    chk("rst_commit_valid", 128'(commit_valid_o), 128'(0));
    @(negedge clk);
    reset_i = 1'b0;

    // Fill to capacity; the 6->8 step is still accepted, the one after is not.
    disp2(); disp2(); disp2();
    idle();
    chk("t1_count6", 128'(count_o), 128'(6));
    chk("t1_stall_at6", 128'(stall_o), 128'(0));
    disp2();
    chk("t1_count8", 128'(count_o), 128'(8));
    chk("t1_stall_at8", 128'(stall_o), 128'(1));
    disp2();
    chk("t1_rejected", 128'(count_o), 128'(8));

    // Out-of-order completion, then in-order retire.
    cpl1(4'd2, 70'h22);
    idle();
    chk("t2_not_ready", 128'(commit_valid_o), 128'(2'b00));
    cpl1(4'd1, 70'h11);
    idle();
    chk("t2_ready", 128'(commit_valid_o), 128'(2'b11));
    commit_cnt_i = 2'd2;
    cycle();
    idle();
    rd_tag_i = {4'd2, 4'd1};
    #1;
    chk("t2_count", 128'(count_o), 128'(6));
    chk("t2_head_tag", 128'(commit_tag_o[TW-1:0]), 128'(3));
    chk("t2_freed", 128'(rd_done_o), 128'(2'b00));
    @(negedge clk);

    // Same tag on both completion ports with a read in the same cycle.
    idle();
    cpl_valid_i = 2'b11;
    cpl_tag_i   = {4'd3, 4'd3};
    cpl_data_i  = {70'hB, 70'hA};
    rd_tag_i    = {4'd0, 4'd3};
    #1;
    chk("t3_bypass_done", 128'(rd_done_o[0]), 128'(1));
    chk("t3_bypass_data", 128'(rd_data_o[CPL_W-1:0]), 128'(70'hB));
    cycle();
    idle();
    rd_tag_i = {4'd0, 4'd3};
    #1;
    chk("t3_stored", 128'(rd_data_o[CPL_W-1:0]), 128'(70'hB));
    @(negedge clk);

    // Wrap-around tags and dispatch concurrent with commit.
    idle();
    disp_valid_i = 2'b11;
    #1;
    chk("t4_wrap_tags", 128'(disp_tag_o), 128'(8'h21));
    cycle();
    idle();
    chk("t4_full", 128'(count_o), 128'(8));
    idle();
    cpl_valid_i = 2'b11;
    cpl_tag_i   = {4'd5, 4'd4};
    cpl_data_i  = {70'h55, 70'h44};
    cycle();
    idle();
    disp_valid_i = 2'b11;
    commit_cnt_i = 2'd2;
    cycle();
    idle();
    chk("t4_full_commit_only", 128'(count_o), 128'(6));
    cpl1(4'd6, 70'h66);
    idle();
    disp_valid_i = 2'b11;
    commit_cnt_i = 2'd2;
    cycle();
    idle();
    chk("t4_disp_and_commit", 128'(count_o), 128'(6));

    // Flush beats dispatch and commit in the same cycle.
    idle();
    flush_i      = 1'b1;
    disp_valid_i = 2'b11;
    commit_cnt_i = 2'd2;
    cycle();
    idle();
    rd_tag_i = {4'd3, 4'd7};
    #1;
    chk("t5_count", 128'(count_o), 128'(0));
    chk("t5_empty", 128'(empty_o), 128'(1));
    chk("t5_rd_done", 128'(rd_done_o), 128'(2'b00));
    @(negedge clk);

    // Commit request clamped to the single ready lane.
    disp2();
    cpl1(4'd1, 70'h1);
    idle();
    commit_cnt_i = 2'd2;
    cycle();
    idle();
    chk("t6_clamp", 128'(count_o), 128'(1));

    repeat (600) random_cycle();

    // Asynchronous reset between clock edges.
    idle();
    flush_i = 1'b1;
    cycle();
    disp2();
    cpl1(4'd1, 70'h3C);
    idle();
    rd_tag_i = {4'd0, 4'd1};
    #1;
    chk("t6_pre_rd_done", 128'(rd_done_o[0]), 128'(1));
    chk("t6_pre_commit", 128'(commit_valid_o), 128'(2'b01));
    #1;
    reset_i = 1'b1;
    #1;
    chk("t6_async_count", 128'(count_o), 128'(0));
    chk("t6_async_empty", 128'(empty_o), 128'(1));
    chk("t6_async_stall", 128'(stall_o), 128'(0));
    chk("t6_async_commit", 128'(commit_valid_o), 128'(2'b00));
    chk("t6_async_rd", 128'(rd_done_o), 128'(2'b00));
    chk("t6_async_tags", 128'(disp_tag_o), 128'(8'h21));
    mq.delete();
    m_tail = 0;
    @(negedge clk);
    reset_i = 1'b0;

    repeat (200) random_cycle();

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
